// File: rtl/dc_ipu_addr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dc_ipu_addr_pkg
// Purpose  : Shared types for the IPU address-scan sequencer.
//            scan_state_e - sequencer FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package dc_ipu_addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage : dc_ipu_addr_pkg
`default_nettype wire

// File: rtl/dc_ipu_addr_dda.sv
`default_nettype none
// ============================================================================
// Module   : dc_ipu_addr_dda
// Purpose  : One-axis coordinate accumulator. Holds (2n+1)*step for the
//            current pixel/line index n.
// Ports    : clk, nreset (async, active-low), clr (sync clear),
//            init  - load step (index 0),
//            adv   - add 2*step (index n -> n+1),
//            step  - step value, unsigned fixed point,
//            acc   - current accumulator value (wraps mod 2^DATA_WIDTH).
// Revision : 1.0 - initial release
// ============================================================================
module dc_ipu_addr_dda #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  clr,
  input  logic                  init,
  input  logic                  adv,
  input  logic [DATA_WIDTH-1:0] step,
  output logic [DATA_WIDTH-1:0] acc
);

  logic [DATA_WIDTH-1:0] acc_d;
  logic [DATA_WIDTH-1:0] acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (init) begin
      acc_d = step;
    end else if (adv) begin
      acc_d = acc_q + (step << 1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule : dc_ipu_addr_dda
`default_nettype wire

// File: rtl/dc_ipu_addr_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dc_ipu_addr_scan_ctrl
// Purpose  : Raster scan sequencer for the IPU address-compute pipeline.
//            Emits doubled, centre-aligned source coordinates
//            x=(2i+1)*hstep, y=(2j+1)*vstep for a cfg_out_w x cfg_out_h
//            frame over a valid/ready stream.
// Ports    : clk, nreset (async, active-low), clr (sync abort),
//            start, cfg_out_w/h, cfg_hstep/vstep  - frame request/config,
//            out_valid/ready, out_xdata/ydata, out_eol/eof - beat stream,
//            busy (state != IDLE), done (pulse after last beat accepted).
// Revision : 1.0 - initial release
// ============================================================================
module dc_ipu_addr_scan_ctrl
  import dc_ipu_addr_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int FRACT_WIDTH = 12,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  clr,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_out_w,
  input  logic [CNT_WIDTH-1:0]  cfg_out_h,
  input  logic [DATA_WIDTH-1:0] cfg_hstep,
  input  logic [DATA_WIDTH-1:0] cfg_vstep,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_xdata,
  output logic [DATA_WIDTH-1:0] out_ydata,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  busy,
  output logic                  done
);

  // The fixed-point format must leave at least one integer bit.
  generate
    if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
      $error("FRACT_WIDTH must be smaller than DATA_WIDTH");
    end
  endgenerate

  scan_state_e           state_d, state_q;
  logic [CNT_WIDTH-1:0]  w_d, w_q, h_d, h_q;
  logic [CNT_WIDTH-1:0]  x_cnt_d, x_cnt_q, y_cnt_d, y_cnt_q;
  logic [DATA_WIDTH-1:0] hstep_d, hstep_q, vstep_d, vstep_q;
  logic                  out_valid_d, out_valid_q;
  logic                  out_eol_d, out_eol_q, out_eof_d, out_eof_q;
  logic                  busy_d, busy_q, done_d, done_q;
  logic                  x_init, x_adv, y_init, y_adv;
  logic                  xfer;
  logic                  line_end;

  assign xfer     = out_valid_q & out_ready;
  assign line_end = (x_cnt_q == w_q - CNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    hstep_d     = hstep_q;
    vstep_d     = vstep_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    out_valid_d = out_valid_q;
    x_init      = 1'b0;
    x_adv       = 1'b0;
    y_init      = 1'b0;
    y_adv       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          w_d     = cfg_out_w;
          h_d     = cfg_out_h;
          hstep_d = cfg_hstep;
          vstep_d = cfg_vstep;
          x_cnt_d = '0;
          y_cnt_d = '0;
          if ((cfg_out_w == '0) || (cfg_out_h == '0)) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
          end else begin
            state_d     = RUN;
            out_valid_d = 1'b1;
            x_init      = 1'b1;
            y_init      = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          // The registered eof flag marks the final beat of the frame.
          if (out_eof_q) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
          end else if (line_end) begin
            x_cnt_d = '0;
            y_cnt_d = y_cnt_q + CNT_WIDTH'(1);
            x_init  = 1'b1;
            y_adv   = 1'b1;
          end else begin
            x_cnt_d = x_cnt_q + CNT_WIDTH'(1);
            x_adv   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (clr) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      x_cnt_d     = '0;
      y_cnt_d     = '0;
      x_init      = 1'b0;
      x_adv       = 1'b0;
      y_init      = 1'b0;
      y_adv       = 1'b0;
    end

    // Flags are derived from the next-cycle counters so they line up with
    // the registered beat data.
    out_eol_d = out_valid_d && (x_cnt_d == w_d - CNT_WIDTH'(1));
    out_eof_d = out_eol_d && (y_cnt_d == h_d - CNT_WIDTH'(1));
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      hstep_q     <= '0;
      vstep_q     <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      hstep_q     <= hstep_d;
      vstep_q     <= vstep_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // hstep_d/vstep_d carry the incoming config on the start cycle, so the
  // accumulators load the new frame's step in the same edge as the latch.
  dc_ipu_addr_dda #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dda_x (
    .clk    (clk),
    .nreset (nreset),
    .clr    (clr),
    .init   (x_init),
    .adv    (x_adv),
    .step   (hstep_d),
    .acc    (out_xdata)
  );

  dc_ipu_addr_dda #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dda_y (
    .clk    (clk),
    .nreset (nreset),
    .clr    (clr),
    .init   (y_init),
    .adv    (y_adv),
    .step   (vstep_d),
    .acc    (out_ydata)
  );

  assign out_valid = out_valid_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule : dc_ipu_addr_scan_ctrl
`default_nettype wire

// File: tb/tb_dc_ipu_addr_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_ipu_addr_scan_ctrl
// Purpose  : Self-checking bench for dc_ipu_addr_scan_ctrl. Expected beats
//            are computed as (2i+1)*step and queued at frame start; a
//            negedge monitor pops and compares accepted beats, checks done
//            against the beat model and checks hold-under-stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_ipu_addr_scan_ctrl;

  localparam int DW = 24;
  localparam int CW = 12;

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          eol;
    logic          eof;
  } beat_t;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_out_w = '0;
  logic [CW-1:0] cfg_out_h = '0;
  logic [DW-1:0] cfg_hstep = '0;
  logic [DW-1:0] cfg_vstep = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_xdata;
  logic [DW-1:0] out_ydata;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  dc_ipu_addr_scan_ctrl #(
    .DATA_WIDTH  (DW),
    .FRACT_WIDTH (12),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .clr       (clr),
    .start     (start),
    .cfg_out_w (cfg_out_w),
    .cfg_out_h (cfg_out_h),
    .cfg_hstep (cfg_hstep),
    .cfg_vstep (cfg_vstep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xdata (out_xdata),
    .out_ydata (out_ydata),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .done      (done)
  );

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sb[$];
  int    popped = 0;
  bit    saw_done = 0;
  bit    mon_en = 0;
  bit    hold_en = 0;
  bit    zero_pend = 0;
  bit    zero_prev = 0;
  bit    eof_prev = 0;
  bit    stall_prev = 0;
  beat_t held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: done model, hold-under-stall, scoreboard pop.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("done", done, eof_prev || zero_prev);
      zero_prev = zero_pend;
      zero_pend = 0;
      eof_prev  = 0;
      if (hold_en && stall_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_x", out_xdata, held.x);
        chk("hold_y", out_ydata, held.y);
        chk("hold_eol", out_eol, held.eol);
        chk("hold_eof", out_eof, held.eof);
      end
      stall_prev = hold_en && out_valid && !out_ready;
      held.x   = out_xdata;
      held.y   = out_ydata;
      held.eol = out_eol;
      held.eof = out_eof;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 1'b1, 1'b0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("xdata", out_xdata, e.x);
          chk("ydata", out_ydata, e.y);
          chk("eol", out_eol, e.eol);
          chk("eof", out_eof, e.eof);
          popped++;
          eof_prev = e.eof;
        end
      end
      if (done) saw_done = 1;
    end
  end

  // Drive a start pulse and queue the expected beats of the frame.
  task automatic start_frame(input int w, input int h, input logic [DW-1:0] hs,
                             input logic [DW-1:0] vs);
    beat_t e;
    @(posedge clk);
    #1;
    cfg_out_w = CW'(w);
    cfg_out_h = CW'(h);
    cfg_hstep = hs;
    cfg_vstep = vs;
    start     = 1'b1;
    popped    = 0;
    saw_done  = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        e.x   = DW'((2 * x + 1) * hs);
        e.y   = DW'((2 * y + 1) * vs);
        e.eol = (x == w - 1);
        e.eof = (x == w - 1) && (y == h - 1);
        sb.push_back(e);
      end
    end
    if (w == 0 || h == 0) zero_pend = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1'b1);
    chk("start_valid", out_valid, (w != 0 && h != 0));
  endtask

  // Wait for the frame to drain and done to pulse, bounded.
  task automatic wait_frame(input int nbeats, input bit bp);
    int i;
    i = 0;
    while (!(saw_done && sb.size() == 0) && i < 400) begin
      @(posedge clk);
      #1;
      if (bp) out_ready = 1'($urandom_range(0, 1));
      i++;
    end
    chk("frame_timeout", (saw_done && sb.size() == 0), 1'b1);
    out_ready = 1'b1;
    chk("nbeats", popped, nbeats);
    @(posedge clk);
    #1;
    chk("idle_after", busy, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_x"}, out_xdata, '0);
    chk({tag, "_y"}, out_ydata, '0);
    chk({tag, "_eol"}, out_eol, 1'b0);
    chk({tag, "_eof"}, out_eof, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    @(negedge clk);
    chk_zero_outputs("reset");
    mon_en  = 1;
    hold_en = 1;

    // Basic frame, ready held high.
    start_frame(4, 2, 24'h800, 24'h800);
    wait_frame(8, 0);

    // Same frame with pseudo-random backpressure.
    start_frame(4, 2, 24'h800, 24'h800);
    wait_frame(8, 1);

    // Single-column and single-line frames, with a step that wraps.
    start_frame(1, 3, 24'h1234, 24'h0A00);
    wait_frame(3, 1);
    start_frame(3, 1, 24'hFFF000, 24'h400000);
    wait_frame(3, 0);

    // Zero-size frame: done one cycle after start, busy for one cycle.
    start_frame(0, 3, 24'h800, 24'h800);
    @(negedge clk);
    chk("zero_busy_drop", busy, 1'b0);
    chk("zero_no_beats", popped, 0);

    // Abort with clr while beat 2 is stalled.
    start_frame(4, 2, 24'h800, 24'h800);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    hold_en   = 0;
    out_ready = 1'b0;
    clr       = 1'b1;
    @(negedge clk);
    chk("clr_beat2_x", out_xdata, 24'h2800);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_valid", out_valid, 1'b0);
    chk("clr_busy", busy, 1'b0);
    chk("clr_popped", popped, 2);
    sb.delete();
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    hold_en   = 1;
    start_frame(4, 2, 24'h800, 24'h300);
    wait_frame(8, 0);

    // start and width change mid-frame are ignored.
    start_frame(4, 2, 24'h200, 24'h100);
    @(posedge clk);
    #1;
    start     = 1'b1;
    cfg_out_w = CW'(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_frame(8, 0);

    // Asynchronous reset mid-frame.
    start_frame(4, 2, 24'h300, 24'h500);
    @(posedge clk);
    #1;
    hold_en = 0;
    #2;
    nreset = 1'b0;
    #1;
    chk_zero_outputs("arst");
    sb.delete();
    @(posedge clk);
    #1 nreset = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_idle_busy", busy, 1'b0);
    chk("arst_idle_valid", out_valid, 1'b0);
    hold_en = 1;

    start_frame(2, 2, 24'h800, 24'h800);
    wait_frame(4, 1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dc_ipu_addr_scan_ctrl
`default_nettype wire

// File: doc/dc_ipu_addr_scan_ctrl.md
# dc_ipu_addr_scan_ctrl

Scan sequencer for the IPU address-compute pipeline. It walks an output frame of cfg_out_w × cfg_out_h pixels in raster order and generates the doubled, centre-aligned fixed-point source coordinate stream for the X and Y address-compute lanes. The downstream final stage subtracts 1.0 and halves each coordinate, giving (i+0.5)·step−0.5. The block sits at the head of the address-compute chain, behind a valid/ready handshake. It is started once per frame by the display controller.

## Interface
- DATA_WIDTH, 24: width of coordinate accumulators and output data.
- FRACT_WIDTH, 12: fractional bits of step and output data.
- CNT_WIDTH, 12: width of pixel/line counters and size config.
- clk  in  1  clock.
- nreset  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous abort; returns to IDLE.
- start  in  1  frame start request; sampled only in IDLE.
- cfg_out_w  in  CNT_WIDTH  output pixels per line.
- cfg_out_h  in  CNT_WIDTH  output lines per frame.
- cfg_hstep  in  DATA_WIDTH  horizontal source/dest ratio, unsigned fixed point.
- cfg_vstep  in  DATA_WIDTH  vertical ratio, same format.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts beat.
- out_xdata  out  DATA_WIDTH  (2x+1)·hstep.
- out_ydata  out  DATA_WIDTH  (2y+1)·vstep.
- out_eol  out  1  last pixel of line.
- out_eof  out  1  last pixel of frame.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- FSM states and transitions:
  - IDLE: start → RUN, or → DONE if cfg_out_w==0 or cfg_out_h==0.
  - RUN: last beat accepted → DONE.
  - DONE: unconditional → IDLE after one cycle.
- On start: cfg_* are latched into internal registers. Later cfg changes do not affect the frame. x_cnt=0, y_cnt=0, xacc=hstep, yacc=vstep.
- Beat transfers when out_valid && out_ready. On transfer:
  - if x_cnt<w−1: x_cnt++, xacc += 2·hstep.
  - else: x_cnt=0, xacc=hstep, y_cnt++, yacc += 2·vstep.
- out_eol = (x_cnt==w−1). out_eof = out_eol && (y_cnt==h−1).
- Arithmetic: 2·step is formed by a left shift. Accumulators wrap modulo 2^DATA_WIDTH. Range checking is the configuring software's responsibility.
- start while busy: ignored. start in the same cycle as clr: clr wins.
- clr in any state:
  - next cycle IDLE, out_valid=0, busy=0.
  - no done pulse; the pending beat is discarded.
- Reset mid-frame: same effect as clr, applied asynchronously.

## Timing
- Reset values: out_valid=0, out_xdata=0, out_ydata=0, out_eol=0, out_eof=0, busy=0, done=0. All internal counters and accumulators are 0.
- Start latency: start high in IDLE at cycle N → busy=1 and out_valid=1 at N+1.
- Throughput: one beat per cycle while out_ready is held high.
- Outputs are registered, with no combinational path from out_ready to out_valid or data.
- While out_valid && !out_ready, all out_* hold stable.
- out_valid never drops without a transfer, except on clr or reset.
- Last transfer at cycle M → done=1 at M+1, IDLE at M+2. A start at M+2 is accepted.
- Zero-size frame: start at N → done=1 at N+1, with no beats.

## Structure
- Package dc_ipu_addr_pkg:
  - state enum typedef scan_state_e {IDLE, RUN, DONE}.
  - no other shared constants.
- Sub-module dc_ipu_addr_dda: one instance per axis.
  - Ports: clk, nreset, clr, init, adv, step → acc.
  - init loads step; adv adds step<<1.
- Counters, FSM, and the output register live in the top.

## Test plan
- Run w=4, h=2, hstep=vstep=0x800, FRACT_WIDTH=12, ready=1. Expected:
  - xdata = 0x800, 0x1800, 0x2800, 0x3800, then repeats.
  - ydata = 0x800 on line 0, 0x1800 on line 1.
  - eol on beats 3 and 7; eof on beat 7 only.
  - done one cycle after beat 7.
- Backpressure: toggle out_ready pseudo-randomly. The stalled beat holds all outputs, with no lost or duplicated beats; 8 beats total, same sequence as the first test.
- Zero size: w=0, h=3, start → done at +1, out_valid never 1, busy high for one cycle.
- clr on beat 2 with out_valid=1, ready=0 → next cycle IDLE, out_valid=0, no done. A new start restarts at xdata=hstep.
- start asserted during RUN, and cfg_out_w changed mid-frame → both ignored; the frame completes with the latched w.
- Async nreset pulse mid-frame → all outputs 0 immediately. After release, the block stays idle until start.
